// File: rtl/ddp_pkt_trim_pkg.sv
// Shared definitions for the DDP packet trimmer: RDMAP opcodes, opcode field
// offsets within the payload, FSM state encoding and packet classes.
package ddp_pkt_trim_pkg;

  localparam int OPC_W = 4;

  // The opcode sits at data[DATA_W-OPC_MSB_OFS : DATA_W-OPC_LSB_OFS].
  localparam int OPC_MSB_OFS = 13;
  localparam int OPC_LSB_OFS = 16;

  localparam logic [OPC_W-1:0] REQ_OPCODE  = 4'h1;
  localparam logic [OPC_W-1:0] ACK_OPCODE  = 4'h2;
  localparam logic [OPC_W-1:0] SEND_OPCODE = 4'h3;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_TRIM = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_PASS = 2'd0,
    CLS_TRIM = 2'd1,
    CLS_DROP = 2'd2
  } cls_t;

endpackage

// File: rtl/ddp_trim_fifo.sv
// Output FIFO for the packet trimmer: DEPTH entries of W bits, head visible
// combinationally, extra pointer bit to tell full from empty.
module ddp_trim_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] push_data,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately left unreset; only the pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ddp_pkt_trim.sv
// DDP packet trimmer: classifies packets at sop, trims REQ/ACK to one beat,
// drops masked opcodes. Statistics counters exist only with DDP_TRIM_STATS_EN.
module ddp_pkt_trim
  import ddp_pkt_trim_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DATA_W/8)+1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_W+CNT_W+1:0] inData,
  input  logic                    inValid,
  output logic                    inPop,
  output logic [DATA_W+CNT_W+1:0] outData,
  output logic                    outValid,
  output logic                    outEmpty,
  input  logic                    outPop,
  input  logic [CNT_W-1:0]        cfgReqLen,
  input  logic [CNT_W-1:0]        cfgAckLen,
  input  logic [15:0]             cfgDropMask,
  input  logic                    statClr,
  output logic [31:0]             trimCnt,
  output logic [31:0]             dropCnt,
  output logic [31:0]             discCnt,
  output logic [15:0]             errCnt
);

  localparam int W = DATA_W + CNT_W + 2;
  localparam logic [CNT_W-1:0] BEAT_BYTES = CNT_W'(DATA_W/8);

  state_t            state;
  state_t            state_nxt;
  cls_t              cls;
  logic [CNT_W-1:0]  cls_len;
  logic [CNT_W-1:0]  trim_len;
  logic              in_sop;
  logic              in_eop;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] payload;
  logic [W-1:0]      push_data;
  logic              push_req;
  logic              discard;
  logic              trim_evt;
  logic              drop_evt;
  logic              err_evt;
  logic              push;
  logic              full;
  logic              empty;
  logic              err_clr;

  assign in_sop  = inData[W-1];
  assign in_eop  = inData[W-2];
  assign payload = inData[DATA_W-1:0];
  assign opcode  = inData[DATA_W-OPC_MSB_OFS:DATA_W-OPC_LSB_OFS];

  always_comb begin
    cls     = CLS_PASS;
    cls_len = '0;
    if (cfgDropMask[opcode]) begin
      cls = CLS_DROP;
    end else if (opcode == REQ_OPCODE) begin
      cls     = CLS_TRIM;
      cls_len = cfgReqLen;
    end else if (opcode == ACK_OPCODE) begin
      cls     = CLS_TRIM;
      cls_len = cfgAckLen;
    end
  end

  // Zero means "whole beat"; anything beyond one beat clamps to the beat size.
  assign trim_len = (cls_len == '0 || cls_len > BEAT_BYTES) ? BEAT_BYTES : cls_len;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    push_data = inData;
    push_req  = 1'b0;
    discard   = 1'b0;
    trim_evt  = 1'b0;
    drop_evt  = 1'b0;
    err_evt   = 1'b0;
    if (in_sop) begin
      // A sop always starts a new packet, even if it cuts a discard short.
      err_evt = (state != ST_PASS);
      case (cls)
        CLS_DROP: begin
          discard   = 1'b1;
          drop_evt  = 1'b1;
          state_nxt = in_eop ? ST_PASS : ST_DROP;
        end
        CLS_TRIM: begin
          push_req  = 1'b1;
          trim_evt  = 1'b1;
          push_data = {1'b1, 1'b1, trim_len, payload};
          state_nxt = in_eop ? ST_PASS : ST_TRIM;
        end
        default: begin
          push_req  = 1'b1;
          state_nxt = ST_PASS;
        end
      endcase
    end else if (state == ST_PASS) begin
      push_req = 1'b1;
    end else begin
      discard = 1'b1;
      if (in_eop) state_nxt = ST_PASS;
    end
  end

  // Gating with reset keeps inPop low for the whole reset window.
  assign push  = reset & inValid & push_req & ~full;
  assign inPop = push | (reset & inValid & discard);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     state <= ST_PASS;
    else if (inPop) state <= state_nxt;
  end

  ddp_trim_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_data (push_data),
    .push      (push),
    .pop       (outPop),
    .head      (outData),
    .empty     (empty),
    .full      (full)
  );

  assign outEmpty = empty;
  assign outValid = ~empty;

`ifdef DDP_TRIM_STATS_EN
  logic [31:0] trim_q;
  logic [31:0] drop_q;
  logic [31:0] disc_q;
  logic        trim_fire;
  logic        drop_fire;
  logic        disc_fire;

  assign trim_fire = inPop & trim_evt;
  assign drop_fire = inPop & drop_evt;
  // Every consumed beat that does not reach the FIFO counts as discarded.
  assign disc_fire = inPop & ~push;
  assign err_clr   = statClr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trim_q <= '0;
      drop_q <= '0;
      disc_q <= '0;
    end else if (statClr) begin
      trim_q <= '0;
      drop_q <= '0;
      disc_q <= '0;
    end else begin
      if (trim_fire && !(&trim_q)) trim_q <= trim_q + 32'd1;
      if (drop_fire && !(&drop_q)) drop_q <= drop_q + 32'd1;
      if (disc_fire && !(&disc_q)) disc_q <= disc_q + 32'd1;
    end
  end

  assign trimCnt = trim_q;
  assign dropCnt = drop_q;
  assign discCnt = disc_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = statClr ^ trim_evt ^ drop_evt;
  assign err_clr         = 1'b0;
  assign trimCnt         = '0;
  assign dropCnt         = '0;
  assign discCnt         = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                               errCnt <= '0;
    else if (err_clr)                         errCnt <= '0;
    else if (inPop && err_evt && !(&errCnt))  errCnt <= errCnt + 16'd1;
  end

endmodule

// File: tb/tb_ddp_pkt_trim.sv
// Self-checking bench for ddp_pkt_trim: a queue-based packet model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ddp_pkt_trim;
  import ddp_pkt_trim_pkg::*;

  localparam int DATA_W = 256;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = $clog2(DATA_W/8)+1;
  localparam int W      = DATA_W + CNT_W + 2;
  localparam int BEAT_B = DATA_W/8;

`ifdef DDP_TRIM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [W-1:0]     inData = '0;
  logic             inValid = 1'b0;
  logic             inPop;
  logic [W-1:0]     outData;
  logic             outValid;
  logic             outEmpty;
  logic             outPop = 1'b0;
  logic [CNT_W-1:0] cfgReqLen = '0;
  logic [CNT_W-1:0] cfgAckLen = '0;
  logic [15:0]      cfgDropMask = '0;
  logic             statClr = 1'b0;
  logic [31:0]      trimCnt;
  logic [31:0]      dropCnt;
  logic [31:0]      discCnt;
  logic [15:0]      errCnt;

  int checks = 0;
  int errors = 0;

  ddp_pkt_trim #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .inData      (inData),
    .inValid     (inValid),
    .inPop       (inPop),
    .outData     (outData),
    .outValid    (outValid),
    .outEmpty    (outEmpty),
    .outPop      (outPop),
    .cfgReqLen   (cfgReqLen),
    .cfgAckLen   (cfgAckLen),
    .cfgDropMask (cfgDropMask),
    .statClr     (statClr),
    .trimCnt     (trimCnt),
    .dropCnt     (dropCnt),
    .discCnt     (discCnt),
    .errCnt      (errCnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] make_beat(input bit sop, input bit eop,
                                             input logic [CNT_W-1:0] cnt, input logic [3:0] opc);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    d[DATA_W-13 -: 4] = opc;
    return {sop, eop, cnt, d};
  endfunction

  // ---------------- behavioural model and per-cycle compare ----------------
  logic [W-1:0] mq[$];
  bit           m_discard;
  int           m_trim, m_drop, m_disc, m_err;

  always @(negedge clock) begin : model
    logic [W-1:0] nb;
    logic [3:0]   opc;
    bit           acc, pushd, m_full, sop_b, eop_b;
    int           cls, len, tl;
    if (!reset) begin
      check("rst_inPop", W'(inPop), '0);
      check("rst_outEmpty", W'(outEmpty), W'(1'b1));
      check("rst_outValid", W'(outValid), '0);
      check("rst_cnts", W'({trimCnt, dropCnt, discCnt, errCnt}), '0);
      mq.delete();
      m_discard = 0;
      m_trim = 0; m_drop = 0; m_disc = 0; m_err = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      sop_b  = inData[W-1];
      eop_b  = inData[W-2];
      opc    = inData[DATA_W-13 -: 4];
      nb     = inData;
      acc    = 0;
      pushd  = 0;
      cls    = 0;
      if (inValid) begin
        if (sop_b) begin
          len = 0;
          if (cfgDropMask[opc])       cls = 2;
          else if (opc == REQ_OPCODE) begin cls = 1; len = int'(cfgReqLen); end
          else if (opc == ACK_OPCODE) begin cls = 1; len = int'(cfgAckLen); end
          if (cls == 2) acc = 1;
          else begin
            acc   = !m_full;
            pushd = acc;
            if (cls == 1) begin
              tl = (len == 0 || len > BEAT_B) ? BEAT_B : len;
              nb = {1'b1, 1'b1, CNT_W'(tl), inData[DATA_W-1:0]};
            end
          end
        end else if (!m_discard) begin
          acc   = !m_full;
          pushd = acc;
        end else begin
          acc = 1;
        end
      end

      check("inPop", W'(inPop), W'(inValid && acc));
      check("outEmpty", W'(outEmpty), W'(mq.size() == 0));
      check("outValid", W'(outValid), W'(mq.size() != 0));
      if (mq.size() != 0) check("outData", outData, mq[0]);
      check("trimCnt", W'(trimCnt), W'(STATS ? m_trim : 0));
      check("dropCnt", W'(dropCnt), W'(STATS ? m_drop : 0));
      check("discCnt", W'(discCnt), W'(STATS ? m_disc : 0));
      check("errCnt", W'(errCnt), W'(m_err));

      if (outPop && mq.size() != 0) void'(mq.pop_front());
      if (pushd) mq.push_back(nb);
      if (acc) begin
        if (sop_b) begin
          if (m_discard && m_err < 65535) m_err++;
          m_discard = (cls != 0) && !eop_b;
          if (cls == 1) m_trim++;
          if (cls == 2) m_drop++;
        end else if (m_discard) begin
          m_discard = !eop_b;
        end
        if (!pushd) m_disc++;
      end
      if (statClr && STATS) begin
        m_trim = 0; m_drop = 0; m_disc = 0; m_err = 0;
      end
    end
  end

  // ---------------- driver helpers (all start and end at posedge+1) ----------------
  task automatic send(input logic [W-1:0] beat);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    inData  = beat;
    inValid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = inPop;
      @(posedge clock); #1;
      n++;
    end
    inValid = 1'b0;
    check("send_accept", W'(acc), W'(1'b1));
  endtask

  task automatic pop_one();
    outPop = 1'b1;
    @(posedge clock); #1;
    outPop = 1'b0;
  endtask

  task automatic clear_stats();
    statClr = 1'b1;
    @(posedge clock); #1;
    statClr = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    outPop = 1'b1;
    for (int n = 0; n < 2*DEPTH + 8 && !done; n++) begin
      @(negedge clock);
      done = outEmpty;
      @(posedge clock); #1;
    end
    outPop = 1'b0;
    check("drain_empty", W'(done), W'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] b[6];
    logic [3:0]   opcs[6];
    logic [W-1:0] cur;
    bit           have;
    int           rem;

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // 4-beat REQ trimmed to 10 bytes
    cfgReqLen = CNT_W'(10);
    clear_stats();
    b[0] = make_beat(1, 0, CNT_W'(32), REQ_OPCODE);
    for (int i = 1; i < 4; i++) b[i] = make_beat(0, i == 3, CNT_W'(32), 4'h0);
    for (int i = 0; i < 4; i++) send(b[i]);
    @(negedge clock);
    check("t_req_beat", outData, {2'b11, CNT_W'(10), b[0][DATA_W-1:0]});
    check("t_req_trim", W'(trimCnt), W'(STATS ? 1 : 0));
    check("t_req_disc", W'(discCnt), W'(STATS ? 3 : 0));
    @(posedge clock); #1;
    pop_one();
    @(negedge clock);
    check("t_req_single", W'(outEmpty), W'(1'b1));
    @(posedge clock); #1;

    // opcode 5 dropped by mask, following SEND passes
    clear_stats();
    cfgDropMask = 16'h0020;
    b[0] = make_beat(1, 0, CNT_W'(32), 4'h5);
    b[1] = make_beat(0, 0, CNT_W'(32), 4'h5);
    b[2] = make_beat(0, 1, CNT_W'(7), 4'h5);
    for (int i = 0; i < 3; i++) send(b[i]);
    @(negedge clock);
    check("t_drop_empty", W'(outEmpty), W'(1'b1));
    check("t_drop_cnt", W'(dropCnt), W'(STATS ? 1 : 0));
    @(posedge clock); #1;
    b[3] = make_beat(1, 0, CNT_W'(32), SEND_OPCODE);
    b[4] = make_beat(0, 1, CNT_W'(3), 4'h9);
    send(b[3]);
    send(b[4]);
    @(negedge clock);
    check("t_send_b0", outData, b[3]);
    @(posedge clock); #1;
    pop_one();
    @(negedge clock);
    check("t_send_b1", outData, b[4]);
    @(posedge clock); #1;
    pop_one();
    cfgDropMask = 16'h0000;

    // fill FIFO, hold next beat, release with one outPop
    for (int i = 0; i < DEPTH; i++) send(make_beat(1, 1, CNT_W'(32), SEND_OPCODE));
    inData  = make_beat(1, 1, CNT_W'(8), SEND_OPCODE);
    inValid = 1'b1;
    @(negedge clock);
    check("t_full_held0", W'(inPop), '0);
    @(posedge clock); #1;
    @(negedge clock);
    check("t_full_held1", W'(inPop), '0);
    @(posedge clock); #1;
    outPop = 1'b1;
    @(negedge clock);
    check("t_full_same_cycle", W'(inPop), '0);
    @(posedge clock); #1;
    outPop = 1'b0;
    @(negedge clock);
    check("t_full_accept", W'(inPop), W'(1'b1));
    @(posedge clock); #1;
    inValid = 1'b0;
    drain();

    // ACK cut short by a new sop on its third beat
    clear_stats();
    cfgAckLen = CNT_W'(20);
    b[0] = make_beat(1, 0, CNT_W'(32), ACK_OPCODE);
    b[1] = make_beat(0, 0, CNT_W'(32), 4'h0);
    b[2] = make_beat(1, 0, CNT_W'(16), SEND_OPCODE);
    b[3] = make_beat(0, 1, CNT_W'(8), 4'h0);
    for (int i = 0; i < 4; i++) send(b[i]);
    @(negedge clock);
    check("t_err_cnt", W'(errCnt), W'(1));
    check("t_err_ack", outData, {2'b11, CNT_W'(20), b[0][DATA_W-1:0]});
    @(posedge clock); #1;
    pop_one();
    @(negedge clock);
    check("t_err_new0", outData, b[2]);
    @(posedge clock); #1;
    pop_one();
    @(negedge clock);
    check("t_err_new1", outData, b[3]);
    @(posedge clock); #1;
    pop_one();

    // reset in the middle of a trimmed packet
    cfgReqLen = CNT_W'(12);
    send(make_beat(1, 0, CNT_W'(32), REQ_OPCODE));
    send(make_beat(0, 0, CNT_W'(32), 4'h0));
    inData  = make_beat(0, 0, CNT_W'(32), 4'h0);
    inValid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("t_rst_empty", W'(outEmpty), W'(1'b1));
    check("t_rst_valid", W'(outValid), '0);
    check("t_rst_inpop", W'(inPop), '0);
    @(posedge clock); #1;
    inValid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    b[0] = make_beat(1, 0, CNT_W'(32), REQ_OPCODE);
    send(b[0]);
    send(make_beat(0, 1, CNT_W'(32), 4'h0));
    @(negedge clock);
    check("t_rst_req", outData, {2'b11, CNT_W'(12), b[0][DATA_W-1:0]});
    check("t_rst_noerr", W'(errCnt), '0);
    @(posedge clock); #1;
    pop_one();

    // single-beat REQ with zero length keeps full beat, FSM stays in PASS
    cfgReqLen = '0;
    b[0] = make_beat(1, 1, CNT_W'(5), REQ_OPCODE);
    b[1] = make_beat(0, 1, CNT_W'(9), REQ_OPCODE);
    send(b[0]);
    send(b[1]);
    @(negedge clock);
    check("t_len0_beat", outData, {2'b11, CNT_W'(32), b[0][DATA_W-1:0]});
    @(posedge clock); #1;
    pop_one();
    @(negedge clock);
    check("t_len0_pass", outData, b[1]);
    @(posedge clock); #1;
    pop_one();

    // randomized traffic
    opcs[0] = REQ_OPCODE; opcs[1] = ACK_OPCODE; opcs[2] = SEND_OPCODE;
    opcs[3] = 4'h0;       opcs[4] = 4'h5;       opcs[5] = 4'h9;
    have = 0;
    rem = 0;
    cur = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        if (rem == 0 || $urandom_range(0, 15) == 0) begin
          rem = $urandom_range(1, 5);
          if ($urandom_range(0, 3) == 0) begin
            cfgReqLen   = CNT_W'($urandom_range(0, 40));
            cfgAckLen   = CNT_W'($urandom_range(0, 40));
            cfgDropMask = 16'($urandom & $urandom & $urandom);
          end
          cur = make_beat(1, rem == 1, CNT_W'($urandom_range(1, 32)), opcs[$urandom_range(0, 5)]);
        end else begin
          cur = make_beat(0, rem == 1, CNT_W'($urandom_range(1, 32)), 4'($urandom));
        end
        rem--;
        have = 1;
      end
      inData  = cur;
      inValid = have;
      outPop  = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      statClr = ($urandom_range(0, 199) == 0);
      @(negedge clock);
      if (have && inPop) have = 0;
      @(posedge clock); #1;
    end
    inValid = 1'b0;
    statClr = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
